// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// It decides advance, hold, bubble and flush for each pipe register and traps a hung data memory.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic [1:0]       ID_PCSrc,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             MEM_Req,
    input  logic             mem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Hold,
    output logic             MEM_WB_Bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbgState
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } stateT;

    stateT             state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;

    // Memory handshake: MEM_Req is the request, mem_ready completes it in the same cycle;
    // any cycle with MEM_Req high and mem_ready low is a wait cycle that freezes the pipe.
    logic memStall;
    logic freeze;
    logic exMatch, memMatch;
    logic loadUse, branchHazard, hazard;

    assign memStall = MEM_Req & ~mem_ready;
    assign freeze   = memStall | (state == ERR);

    // r==0 never matches: $0 is hardwired and cannot carry a dependency.
    assign exMatch  = (EX_WriteReg != 5'd0) &
                      ((EX_WriteReg == ID_Rs) | (ID_UsesRt & (EX_WriteReg == ID_Rt)));
    assign memMatch = (MEM_WriteReg != 5'd0) &
                      ((MEM_WriteReg == ID_Rs) | (ID_UsesRt & (MEM_WriteReg == ID_Rt)));

    assign loadUse      = EX_MemRead & exMatch;
    assign branchHazard = (ID_Branch | (ID_PCSrc == 2'b10)) &
                          ((EX_RegWrite & exMatch) | (MEM_MemRead & memMatch));
    assign hazard       = loadUse | branchHazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            RUN: begin
                if (memStall) begin
                    stateNext   = MEM_WAIT;
                    waitCntNext = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    stateNext = RUN;
                end else if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    stateNext = ERR;
                end else begin
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            ERR:     stateNext = ERR;
            default: stateNext = RUN;
        endcase
    end

    // Priority: reset, then freeze, then hazard stall, then normal advance.
    // A stalled or frozen branch stays in ID and flushes only when it finally advances.
    always_comb begin
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Hold   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        if (reset) begin
            PC_Write = 1'b0;
        end else if (freeze) begin
            EX_MEM_Hold   = 1'b1;
            MEM_WB_Bubble = 1'b1;
        end else if (hazard) begin
            ID_EX_Flush = 1'b1;
        end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            IF_ID_Flush = (ID_PCSrc != 2'b00);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PC_Write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (IF_ID_Flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign mem_err  = (state == ERR);
    assign dbgState = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one task per scenario with hand-computed expectations.
// Control outputs are compared as {PC_Write,IF_ID_Write,IF_ID_Flush,ID_EX_Flush,EX_MEM_Hold,MEM_WB_Bubble}.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
    logic        ID_UsesRt, ID_Branch, EX_MemRead, EX_RegWrite, MEM_MemRead, MEM_Req, mem_ready;
    logic [1:0]  ID_PCSrc;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold, MEM_WB_Bubble, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  dbgState;
    logic [5:0]  ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] C_OFF    = 6'b000000;
    localparam logic [5:0] C_RUN    = 6'b110000;
    localparam logic [5:0] C_FLUSH  = 6'b111000;
    localparam logic [5:0] C_STALL  = 6'b000100;
    localparam logic [5:0] C_FREEZE = 6'b000011;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
        .ID_PCSrc(ID_PCSrc), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
        .MEM_Req(MEM_Req), .mem_ready(mem_ready),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Hold(EX_MEM_Hold), .MEM_WB_Bubble(MEM_WB_Bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbgState(dbgState)
    );

    assign ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold, MEM_WB_Bubble};

    task automatic idle_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_Branch = 1'b0; ID_PCSrc = 2'b00;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0; MEM_Req = 1'b0; mem_ready = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        MEM_Req = 1'b1; ID_PCSrc = 2'b01; EX_MemRead = 1'b1; EX_WriteReg = 5'd1; ID_Rs = 5'd1;
        #1;
        n_checks++;
        if (ctrl !== C_OFF) begin $display("FAIL reset_ctrl: got %b want %b", ctrl, C_OFF); n_fail++; end
        n_checks++;
        if ({mem_err, dbgState, stall_cnt, flush_cnt} !== 35'd0) begin
            $display("FAIL reset_state: mem_err=%b state=%0d stall=%0d flush=%0d want all 0",
                     mem_err, dbgState, stall_cnt, flush_cnt);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin $display("FAIL reset_release_ctrl: got %b want %b", ctrl, C_RUN); n_fail++; end
    endtask

    task automatic test_load_use();
        apply_reset();
        ID_Rs = 5'd2; ID_Rt = 5'd4; ID_UsesRt = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd2;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin $display("FAIL load_use_stall: got %b want %b", ctrl, C_STALL); n_fail++; end
        @(negedge clk);
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        MEM_MemRead = 1'b1; MEM_WriteReg = 5'd2;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin $display("FAIL load_use_release: got %b want %b", ctrl, C_RUN); n_fail++; end
        @(negedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 16'd1) begin $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); n_fail++; end
    endtask

    task automatic test_rt_match();
        apply_reset();
        ID_Rs = 5'd7; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin $display("FAIL rt_match_stall: got %b want %b", ctrl, C_STALL); n_fail++; end
        ID_UsesRt = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin $display("FAIL rt_unused_no_stall: got %b want %b", ctrl, C_RUN); n_fail++; end
    endtask

    task automatic test_load_branch();
        apply_reset();
        ID_Rs = 5'd5; ID_Rt = 5'd0; ID_UsesRt = 1'b1; ID_Branch = 1'b1; ID_PCSrc = 2'b01;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd5;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin $display("FAIL load_branch_c1: got %b want %b", ctrl, C_STALL); n_fail++; end
        @(negedge clk);
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        MEM_MemRead = 1'b1; MEM_WriteReg = 5'd5;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin $display("FAIL load_branch_c2: got %b want %b", ctrl, C_STALL); n_fail++; end
        @(negedge clk);
        MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
        #1;
        n_checks++;
        if (ctrl !== C_FLUSH) begin $display("FAIL load_branch_resolve: got %b want %b", ctrl, C_FLUSH); n_fail++; end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({stall_cnt, flush_cnt} !== {16'd2, 16'd1}) begin
            $display("FAIL load_branch_counts: got stall=%0d flush=%0d want stall=2 flush=1", stall_cnt, flush_cnt);
            n_fail++;
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd0;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin $display("FAIL zero_reg_no_stall: got %b want %b", ctrl, C_RUN); n_fail++; end
    endtask

    task automatic test_branch_forms();
        apply_reset();
        ID_Rs = 5'd3; ID_Branch = 1'b1; ID_PCSrc = 2'b01;
        MEM_WriteReg = 5'd3;
        #1;
        n_checks++;
        if (ctrl !== C_FLUSH) begin $display("FAIL alu_in_mem_forwarded: got %b want %b", ctrl, C_FLUSH); n_fail++; end
        MEM_WriteReg = 5'd0; EX_RegWrite = 1'b1; EX_WriteReg = 5'd3;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin $display("FAIL alu_in_ex_branch: got %b want %b", ctrl, C_STALL); n_fail++; end
        ID_Branch = 1'b0; ID_PCSrc = 2'b10;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin $display("FAIL jr_operand_stall: got %b want %b", ctrl, C_STALL); n_fail++; end
        ID_PCSrc = 2'b11;
        #1;
        n_checks++;
        if (ctrl !== C_FLUSH) begin $display("FAIL jump_flush: got %b want %b", ctrl, C_FLUSH); n_fail++; end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        // Branch and load-use both present during the freeze: freeze must win.
        ID_Rs = 5'd6; ID_Branch = 1'b1; ID_PCSrc = 2'b01;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd6;
        MEM_Req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctrl !== C_FREEZE) begin $display("FAIL mem_wait_freeze_c%0d: got %b want %b", i, ctrl, C_FREEZE); n_fail++; end
            @(negedge clk);
        end
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_FLUSH) begin $display("FAIL mem_wait_release: got %b want %b", ctrl, C_FLUSH); n_fail++; end
        n_checks++;
        if (dbgState !== 2'd1) begin $display("FAIL mem_wait_state: got %0d want 1", dbgState); n_fail++; end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if ({dbgState, mem_err, stall_cnt, flush_cnt} !== {2'd0, 1'b0, 16'd3, 16'd1}) begin
            $display("FAIL mem_wait_after: state=%0d err=%b stall=%0d flush=%0d want 0 0 3 1",
                     dbgState, mem_err, stall_cnt, flush_cnt);
            n_fail++;
        end
        // Reset in the middle of a wait abandons the access.
        MEM_Req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dbgState !== 2'd0) begin $display("FAIL reset_mid_wait: got state %0d want 0", dbgState); n_fail++; end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        MEM_Req = 1'b1; mem_ready = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        n_checks++;
        if (mem_err !== 1'b0) begin $display("FAIL timeout_early: got mem_err %b want 0", mem_err); n_fail++; end
        @(negedge clk);
        #1;
        n_checks++;
        if ({mem_err, dbgState} !== {1'b1, 2'd2}) begin
            $display("FAIL timeout_err: got err=%b state=%0d want 1 2", mem_err, dbgState); n_fail++;
        end
        MEM_Req = 1'b0; ID_PCSrc = 2'b11;
        #1;
        n_checks++;
        if (ctrl !== C_FREEZE) begin $display("FAIL err_freeze: got %b want %b", ctrl, C_FREEZE); n_fail++; end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({mem_err, stall_cnt, flush_cnt} !== {1'b1, 16'd19, 16'd0}) begin
            $display("FAIL err_counting: err=%b stall=%0d flush=%0d want 1 19 0", mem_err, stall_cnt, flush_cnt);
            n_fail++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_err, dbgState, stall_cnt, ctrl} !== {1'b0, 2'd0, 16'd0, C_OFF}) begin
            $display("FAIL async_reset_err: err=%b state=%0d stall=%0d ctrl=%b want 0 0 0 000000",
                     mem_err, dbgState, stall_cnt, ctrl);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_saturation();
        apply_reset();
        ID_Rs = 5'd8; EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
        repeat (65534) @(negedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 16'hFFFE) begin $display("FAIL stall_cnt_near_top: got %h want fffe", stall_cnt); n_fail++; end
        repeat (7) @(negedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin $display("FAIL stall_cnt_saturate: got %h want ffff", stall_cnt); n_fail++; end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_rt_match();
        test_load_branch();
        test_zero_reg();
        test_branch_forms();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
